// File: rtl/burst_line_adapter.sv
// burst_line_adapter: turns one cache line read/write into a fixed-length
// burst of memory beats and reassembles returned read beats into a line.
// One transaction at a time. Every output decodes from state and registers only.
module burst_line_adapter #(
   parameter int LINE_SIZE  = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int BURST_LEN  = LINE_SIZE / BEAT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           c_address,
   input  logic                  c_read,
   input  logic                  c_write,
   input  logic [LINE_SIZE-1:0]  c_wdata,
   output logic [LINE_SIZE-1:0]  c_rdata,
   output logic                  c_resp,
   output logic [31:0]           bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic                  bmem_ready,
   input  logic [31:0]           bmem_raddr,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_rvalid
);
   localparam int              CW         = $clog2(BURST_LEN);
   localparam logic [31:0]     ALIGN_MASK = ~32'(LINE_SIZE / 8 - 1);
   localparam logic [CW-1:0]   LAST_BEAT  = CW'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_t;

   state_t                 r_state, w_next;
   logic [31:0]            r_addr;
   logic [CW-1:0]          r_cnt;
   logic [LINE_SIZE-1:0]   r_wline;   // line being written, latched at request
   logic [LINE_SIZE-1:0]   r_buf;     // read assembly buffer
   logic [LINE_SIZE-1:0]   r_rdata;   // last completed read line, held for the cache
   logic [LINE_SIZE-1:0]   w_merged;
   logic                   w_beat_ok;

   // Only beats tagged with our line address count; strays are dropped.
   assign w_beat_ok = (r_state == RD_DATA) && bmem_rvalid && (bmem_raddr == r_addr);
   assign c_rdata   = r_rdata;

   // Assembly buffer with the incoming beat dropped into slot k.
   always_comb begin
      w_merged = r_buf;
      w_merged[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state and output decode; outputs depend on state/registers only.
   always_comb begin
      w_next     = r_state;
      c_resp     = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      case (r_state)
         IDLE: begin
            if (c_write)     w_next = WR_DATA;   // write has priority
            else if (c_read) w_next = RD_REQ;
         end
         RD_REQ: begin
            bmem_read = 1'b1;
            bmem_addr = r_addr;
            if (bmem_ready) w_next = RD_DATA;
         end
         RD_DATA: begin
            if (w_beat_ok && r_cnt == LAST_BEAT) w_next = DONE;
         end
         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_addr  = r_addr;
            bmem_wdata = r_wline[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH];
            if (bmem_ready && r_cnt == LAST_BEAT) w_next = DONE;
         end
         DONE: begin
            c_resp = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath: request latch, beat counter, read assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_cnt   <= '0;
         r_wline <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (c_write) begin
                  r_addr  <= c_address & ALIGN_MASK;
                  r_wline <= c_wdata;
                  r_cnt   <= '0;
               end else if (c_read) begin
                  r_addr  <= c_address & ALIGN_MASK;
                  r_cnt   <= '0;
               end
            end
            RD_DATA: begin
               if (w_beat_ok) begin
                  r_buf <= w_merged;
                  r_cnt <= r_cnt + 1'b1;
                  // Publish the line only when complete so c_rdata holds the
                  // previous read throughout the next one.
                  if (r_cnt == LAST_BEAT) r_rdata <= w_merged;
               end
            end
            WR_DATA: begin
               if (bmem_ready) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_burst_line_adapter.sv
// Directed bench for burst_line_adapter: a transaction-level model checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_burst_line_adapter;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  c_address;
   logic         c_read, c_write;
   logic [255:0] c_wdata, c_rdata;
   logic         c_resp;
   logic [31:0]  bmem_addr, bmem_raddr;
   logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [63:0]  bmem_wdata, bmem_rdata;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   burst_line_adapter dut (
      .clk(clk), .rst(rst), .c_address(c_address), .c_read(c_read),
      .c_write(c_write), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_resp(c_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // Phase of the single outstanding transaction.
   localparam int P_IDLE = 0, P_REQ = 1, P_RBEAT = 2, P_WBEAT = 3, P_RESP = 4;
   int           m_phase = P_IDLE;
   int           m_k     = 0;
   logic [31:0]  m_addr  = '0;
   logic [63:0]  m_wb[4];
   logic [63:0]  m_rb[4];
   logic [255:0] m_line  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = P_IDLE; m_k = 0; m_addr = '0; m_line = '0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               if (c_write || c_read) begin
                  m_addr = {c_address[31:5], 5'b0};
                  m_k    = 0;
                  for (int i = 0; i < 4; i++) m_wb[i] = c_wdata[i*64 +: 64];
                  m_phase = c_write ? P_WBEAT : P_REQ;
               end
            end
            P_REQ: if (bmem_ready) m_phase = P_RBEAT;
            P_RBEAT: begin
               if (bmem_rvalid && bmem_raddr == m_addr) begin
                  m_rb[m_k] = bmem_rdata;
                  if (m_k == 3) begin
                     m_line  = {m_rb[3], m_rb[2], m_rb[1], m_rb[0]};
                     m_phase = P_RESP;
                  end
                  m_k = (m_k + 1) % 4;
               end
            end
            P_WBEAT: begin
               if (bmem_ready) begin
                  if (m_k == 3) m_phase = P_RESP;
                  m_k = (m_k + 1) % 4;
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_resp",  c_resp,     m_phase == P_RESP);
         chk("m_read",  bmem_read,  m_phase == P_REQ);
         chk("m_write", bmem_write, m_phase == P_WBEAT);
         chk("m_addr",  bmem_addr,  (m_phase == P_REQ || m_phase == P_WBEAT) ? m_addr : 32'h0);
         chk("m_wdata", bmem_wdata, (m_phase == P_WBEAT) ? m_wb[m_k] : 64'h0);
         chk("m_rdata", c_rdata,    m_line);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   // Full read: request, beats with optional gaps and a stray beat, then response.
   task automatic do_read(input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [255:0] line, input int gap, input bit stray);
      c_address = a; c_read = 1'b1; bmem_ready = 1'b1;
      step();                                         // RD_REQ
      chk("rd_req", bmem_read, 1'b1);
      chk("rd_addr", bmem_addr, exp_addr);
      step();                                         // waiting for beats
      for (int i = 0; i < 4; i++) begin
         if (stray && i == 1) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_9000; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
         end
         for (int g = 0; g < gap; g++) begin
            bmem_rvalid = 1'b0; step();
         end
         bmem_rvalid = 1'b1; bmem_raddr = exp_addr; bmem_rdata = line[i*64 +: 64];
         step();
      end
      bmem_rvalid = 1'b0;
      chk("rd_resp", c_resp, 1'b1);                   // DONE
      chk("rd_line", c_rdata, line);
      chk("rd_no_rereq", bmem_read, 1'b0);
      step();                                         // IDLE, request still high
      chk("rd_resp_1cyc", c_resp, 1'b0);
      c_read = 1'b0;
   endtask

   localparam logic [255:0] L1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
   localparam logic [255:0] L2 = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                                  64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
   localparam logic [255:0] L3 = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};
   localparam logic [255:0] L4 = {64'hAAAA_0003, 64'hAAAA_0002, 64'hAAAA_0001, 64'hAAAA_0000};
   localparam logic [255:0] L5 = {64'hBBBB_0003, 64'hBBBB_0002, 64'hBBBB_0001, 64'hBBBB_0000};

   initial begin
      rst = 1'b1; c_address = '0; c_read = 1'b0; c_write = 1'b0; c_wdata = '0;
      bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_resp", c_resp, 1'b0);
      chk("rst_rdata", c_rdata, 256'h0);
      chk("rst_bus", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, 98'h0);
      rst = 1'b0;
      step();

      // Basic read, ready always high.
      do_read(32'h0000_1234, 32'h0000_1220, L1, 0, 1'b0);
      step();

      // Write with ready low every other cycle: 8 beat cycles + DONE = 9.
      c_address = 32'h0000_2040; c_wdata = L2; c_write = 1'b1;
      step();
      chk("wr_addr", bmem_addr, 32'h0000_2040);
      chk("wr_d0_held", bmem_wdata, 64'hD0D0_0000_0000_0000);
      for (int i = 0; i < 8; i++) begin
         bmem_ready = (i % 2 == 1);
         if (i == 2) chk("wr_d1", bmem_wdata, 64'hD1D1_0000_0000_0001);
         if (i == 7) chk("wr_d3", bmem_wdata, 64'hD3D3_0000_0000_0003);
         step();
      end
      bmem_ready = 1'b1;
      chk("wr_resp_cyc9", c_resp, 1'b1);
      chk("wr_rdata_hold", c_rdata, L1);
      step();
      c_write = 1'b0;
      step();

      // Gapped beats with a stray tagged beat.
      do_read(32'h0000_3000, 32'h0000_3000, L3, 1, 1'b1);
      step();

      // Read and write together: write first, then the held read.
      c_address = 32'h0000_6010; c_wdata = L2; c_read = 1'b1; c_write = 1'b1; bmem_ready = 1'b1;
      step();
      chk("both_write", bmem_write, 1'b1);
      chk("both_noread", bmem_read, 1'b0);
      step(); step(); step(); step();
      chk("both_resp", c_resp, 1'b1);
      step();
      c_write = 1'b0;                                 // read left high
      do_read(32'h0000_6010, 32'h0000_6000, L4, 0, 1'b0);
      step();

      // Reset after two beats of a read.
      c_address = 32'h0000_4000; c_read = 1'b1;
      step(); step();
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_4000; bmem_rdata = L5[i*64 +: 64];
         step();
      end
      rst = 1'b1; c_read = 1'b0; bmem_rdata = L5[128 +: 64];
      step();
      chk("mid_rst_rdata", c_rdata, 256'h0);
      chk("mid_rst_bus", {c_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 99'h0);
      rst = 1'b0; bmem_rdata = L5[192 +: 64];
      step();                                         // leftover beat in IDLE
      bmem_rvalid = 1'b0;
      step();
      do_read(32'h0000_5008, 32'h0000_5000, L5, 2, 1'b0);
      step(); step();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/burst_line_adapter.md
# burst_line_adapter

Memory-side adapter between the line caches and the banked burst memory. It converts one 256-bit line read or write from a cache (e.g. the read-only fetch cache's `pmem_*` port) into a fixed-length burst of 64-bit beats, and reassembles returned read beats into a full line. It allows a single outstanding transaction and presents the registered-response handshake the caches expect: request held high until a one-cycle `c_resp`.

## Interface
- `LINE_SIZE`, 256, cache line width in bits
- `BEAT_WIDTH`, 64, memory data beat width in bits
- `BURST_LEN`, `LINE_SIZE/BEAT_WIDTH` (4), beats per line; must be a power of two ≥2
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `c_address`  in  32  cache request address; low `log2(LINE_SIZE/8)` bits ignored
- `c_read`  in  1  line read request, held until `c_resp`
- `c_write`  in  1  line write request, held until `c_resp`
- `c_wdata`  in  LINE_SIZE  line to write, stable while `c_write` high
- `c_rdata`  out  LINE_SIZE  assembled read line, valid when `c_resp` high
- `c_resp`  out  1  one-cycle completion pulse
- `bmem_addr`  out  32  line-aligned burst address
- `bmem_read`  out  1  read burst request
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  BEAT_WIDTH  write beat data
- `bmem_ready`  in  1  memory accepts request/beat this cycle
- `bmem_raddr`  in  32  line address tagged on returning read beat
- `bmem_rdata`  in  BEAT_WIDTH  read beat data
- `bmem_rvalid`  in  1  read beat valid

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE.
- IDLE: `c_write` → latch aligned address and `c_wdata`, clear beat counter, go WR_DATA. Else `c_read` → latch aligned address, clear counter, go RD_REQ. Write wins when both are high.
- RD_REQ: `bmem_read`=1, `bmem_addr`=latched address. Advance to RD_DATA when `bmem_ready`=1; otherwise hold.
- RD_DATA: when `bmem_rvalid`=1 and `bmem_raddr`==latched address, write `bmem_rdata` into line bits [BEAT_WIDTH*k +: BEAT_WIDTH], where k is the beat counter, then increment k.
  - A beat with a mismatched `bmem_raddr` is dropped; it does not advance k.
  - Gaps between beats are legal.
  - On the beat with k=BURST_LEN-1, go DONE.
- WR_DATA: `bmem_write`=1, `bmem_addr`=latched address, `bmem_wdata`=latched line slice k.
  - k increments only on `bmem_ready`=1.
  - On the accepted beat with k=BURST_LEN-1, go DONE.
- DONE: `c_resp`=1 for exactly one cycle, then go IDLE unconditionally.
  - For reads, `c_rdata` equals the full assembled line in this cycle and holds until the next read completes.
  - Requests are sampled only in IDLE, so a request still high during DONE does not retrigger.
- Beat counter is log2(BURST_LEN) bits wide and wraps to 0 after the last beat.
- `bmem_rvalid` outside RD_DATA is ignored.
- All outputs decode from state and internal registers only. There is no combinational path from any input to any output.
- Reset (any state, including mid-burst) → IDLE, counter 0, all in-flight beats discarded. Outputs after reset: `c_resp`=0, `c_rdata`=0, `bmem_read`=0, `bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0.

## Timing
- Request seen in IDLE at cycle T → RD_REQ or WR_DATA active at T+1.
- Read with `bmem_ready` held high, first beat L cycles after request acceptance and beats back-to-back: `c_resp` at T+1+L+BURST_LEN.
- Write with `bmem_ready` always high: beats at T+1..T+BURST_LEN, `c_resp` at T+BURST_LEN+1.
- Each `bmem_ready`=0 cycle in RD_REQ/WR_DATA adds exactly one cycle.
- Minimum gap between `c_resp` and the next bus request is 1 cycle (IDLE).
- The cache drops its request the cycle after `c_resp`. A request still high in IDLE after DONE is treated as a new transaction.

## Test plan
- Read 0x0000_1234, `bmem_ready`=1, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `bmem_addr`=0x0000_1220 and `c_rdata`={44..,33..,22..,11..}. `c_resp` is high for exactly 1 cycle.
- Write 0x0000_2040 with line {D3,D2,D1,D0}, `bmem_ready` low every other cycle → D0..D3 each presented until accepted, in order, then `c_resp`. Total duration is 9 cycles after IDLE.
- Read with gapped `rvalid` plus one stray beat tagged 0x0000_9000 → stray beat not stored, line correct, counter unaffected.
- `c_read` and `c_write` asserted together → write burst issued first and no `bmem_read` pulse. With `c_read` left high, a read starts in the IDLE after DONE.
- `rst` asserted after beat 2 of a read → all outputs 0 the next cycle. Remaining beats ignored. A fresh read then completes correctly with no leftover data.
- `c_read` held through DONE → no second `bmem_read` is issued until the state returns to IDLE.
